// File: rtl/squash_input_conditioner.sv
// Button conditioner for solo_squash: synchronise, debounce and shape pause/new-game/up/down.
// Optional PAUSE_TOGGLE_EN: pause button toggles pause_n, and new game forces unpause.
module squash_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_pause_n,
  input  logic btn_new_game_n,
  input  logic btn_up_n,
  input  logic btn_down_n,
  output logic pause_n,
  output logic new_game_n,
  output logic up_key_n,
  output logic down_key_n
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // channel order: 0 pause, 1 new game, 2 up, 3 down
  logic [3:0] raw;
  logic [3:0] stable;

  assign raw = {btn_down_n, btn_up_n, btn_new_game_n, btn_pause_n};

  for (genvar i = 0; i < 4; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   stb_q;
    logic                   sync;

    assign sync      = sync_q[SYNC_STAGES-1];
    assign stable[i] = stb_q;

    // any disagreement-free cycle restarts the count
    always_ff @(posedge clk) begin
      if (reset) begin
        sync_q <= '1;
        cnt_q  <= '0;
        stb_q  <= 1'b1;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw[i]};
        if (sync == stb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
          stb_q <= sync;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  logic ng_prev_q;
  logic ng_press;
  logic both_held;

  assign ng_press  = ng_prev_q & ~stable[1];
  assign both_held = ~stable[2] & ~stable[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      ng_prev_q  <= 1'b1;
      new_game_n <= 1'b1;
      up_key_n   <= 1'b1;
      down_key_n <= 1'b1;
    end else begin
      ng_prev_q  <= stable[1];
      new_game_n <= ~ng_press;
      up_key_n   <= stable[2] | both_held;
      down_key_n <= stable[3] | both_held;
    end
  end

`ifdef PAUSE_TOGGLE_EN
  logic p_prev_q;
  logic p_press;

  assign p_press = p_prev_q & ~stable[0];

  // new game wins over a coincident pause toggle
  always_ff @(posedge clk) begin
    if (reset) begin
      p_prev_q <= 1'b1;
      pause_n  <= 1'b1;
    end else begin
      p_prev_q <= stable[0];
      if (ng_press) begin
        pause_n <= 1'b1;
      end else if (p_press) begin
        pause_n <= ~pause_n;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      pause_n <= 1'b1;
    end else begin
      pause_n <= stable[0];
    end
  end
`endif

endmodule

// File: tb/tb_squash_input_conditioner.sv
// Directed self-checking bench for squash_input_conditioner (DEBOUNCE_CYCLES=8, SYNC_STAGES=2).
module tb_squash_input_conditioner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_pause_n = 1'b1;
  logic btn_new_game_n = 1'b1;
  logic btn_up_n = 1'b1;
  logic btn_down_n = 1'b1;
  logic pause_n;
  logic new_game_n;
  logic up_key_n;
  logic down_key_n;

  int n_checks = 0;
  int n_fail = 0;
  int strobes;

`ifdef PAUSE_TOGGLE_EN
  localparam bit TOGGLE = 1'b1;
`else
  localparam bit TOGGLE = 1'b0;
`endif

  squash_input_conditioner #(
    .DEBOUNCE_CYCLES(8),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_pause_n(btn_pause_n),
    .btn_new_game_n(btn_new_game_n),
    .btn_up_n(btn_up_n),
    .btn_down_n(btn_down_n),
    .pause_n(pause_n),
    .new_game_n(new_game_n),
    .up_key_n(up_key_n),
    .down_key_n(down_key_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] exp);
    chk({tag, ".pause_n"}, pause_n, exp[3]);
    chk({tag, ".new_game_n"}, new_game_n, exp[2]);
    chk({tag, ".up_key_n"}, up_key_n, exp[1]);
    chk({tag, ".down_key_n"}, down_key_n, exp[0]);
  endtask

  task automatic do_reset();
    btn_pause_n = 1'b1;
    btn_new_game_n = 1'b1;
    btn_up_n = 1'b1;
    btn_down_n = 1'b1;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(3);
  endtask

  initial begin
    // reset with every button held down
    tick(1);
    btn_pause_n = 1'b0;
    btn_new_game_n = 1'b0;
    btn_up_n = 1'b0;
    btn_down_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk_all("in_reset", 4'b1111);
    end
    reset = 1'b0;
    tick(1);
    chk_all("post_reset_c1", 4'b1111);
    tick(9);
    chk_all("post_reset_c10", 4'b1111);
    tick(1);
    chk_all("post_reset_c11", {TOGGLE, 3'b011});
    tick(1);
    chk("post_reset_c12.new_game_n", new_game_n, 1'b1);
    do_reset();
    chk_all("clean_idle", 4'b1111);

    // glitch rejection on up
    btn_up_n = 1'b0;
    for (int i = 0; i < 7; i++) begin tick(1); chk("glitch_a", up_key_n, 1'b1); end
    btn_up_n = 1'b1;
    tick(1); chk("glitch_gap", up_key_n, 1'b1);
    btn_up_n = 1'b0;
    for (int i = 0; i < 7; i++) begin tick(1); chk("glitch_b", up_key_n, 1'b1); end
    btn_up_n = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(1); chk("glitch_tail", up_key_n, 1'b1); end
    btn_up_n = 1'b0;
    tick(10);
    chk("up_hold_c10", up_key_n, 1'b1);
    tick(1);
    chk("up_hold_c11", up_key_n, 1'b0);
    btn_up_n = 1'b1;
    tick(10);
    chk("up_rel_c10", up_key_n, 1'b0);
    tick(1);
    chk("up_rel_c11", up_key_n, 1'b1);
    tick(3);

    // new-game strobe, once per debounced press
    btn_new_game_n = 1'b0;
    strobes = 0;
    for (int i = 1; i <= 100; i++) begin
      tick(1);
      if (new_game_n == 1'b0) strobes++;
      if (i == 11) chk("ng_strobe_c11", new_game_n, 1'b0);
      if (i == 12) chk("ng_strobe_c12", new_game_n, 1'b1);
    end
    chk("ng_one_strobe", strobes == 1, 1'b1);
    btn_new_game_n = 1'b1;
    strobes = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (new_game_n == 1'b0) strobes++;
    end
    chk("ng_release_no_strobe", strobes == 0, 1'b1);
    btn_new_game_n = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (new_game_n == 1'b0) strobes++;
    end
    chk("ng_second_strobe", strobes == 1, 1'b1);
    btn_new_game_n = 1'b1;
    tick(15);

    // up/down conflict
    btn_up_n = 1'b0;
    tick(11);
    chk("conf_up.up", up_key_n, 1'b0);
    chk("conf_up.down", down_key_n, 1'b1);
    btn_down_n = 1'b0;
    tick(10);
    chk("conf_add_c10.up", up_key_n, 1'b0);
    tick(1);
    chk("conf_both.up", up_key_n, 1'b1);
    chk("conf_both.down", down_key_n, 1'b1);
    btn_up_n = 1'b1;
    tick(10);
    chk("conf_rel_c10.down", down_key_n, 1'b1);
    tick(1);
    chk("conf_rel_c11.down", down_key_n, 1'b0);
    chk("conf_rel_c11.up", up_key_n, 1'b1);
    btn_down_n = 1'b1;
    tick(12);
    chk("conf_idle.down", down_key_n, 1'b1);

`ifdef PAUSE_TOGGLE_EN
    btn_pause_n = 1'b0;
    tick(10); chk("tog1_c10", pause_n, 1'b1);
    tick(1);  chk("tog1_c11", pause_n, 1'b0);
    btn_pause_n = 1'b1;
    tick(15); chk("tog1_release", pause_n, 1'b0);
    btn_pause_n = 1'b0;
    tick(11); chk("tog2_c11", pause_n, 1'b1);
    btn_pause_n = 1'b1;
    tick(15); chk("tog2_release", pause_n, 1'b1);
    btn_pause_n = 1'b0;
    tick(11); chk("tog3_paused", pause_n, 1'b0);
    btn_pause_n = 1'b1;
    tick(15);
    btn_new_game_n = 1'b0;
    tick(10); chk("ng_unpause_c10", pause_n, 1'b0);
    tick(1);
    chk("ng_unpause_c11.ng", new_game_n, 1'b0);
    chk("ng_unpause_c11.pause", pause_n, 1'b1);
    btn_new_game_n = 1'b1;
    tick(15);
`else
    btn_pause_n = 1'b0;
    tick(10); chk("pause_c10", pause_n, 1'b1);
    tick(1);  chk("pause_c11", pause_n, 1'b0);
    tick(9);  chk("pause_c20", pause_n, 1'b0);
    btn_pause_n = 1'b1;
    tick(10); chk("pause_rel_c10", pause_n, 1'b0);
    tick(1);  chk("pause_rel_c11", pause_n, 1'b1);
    tick(5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/squash_input_conditioner.md
Name: squash_input_conditioner

Overview:
- Upstream stage for solo_squash. Conditions the four raw active-low push-buttons (pause, new game, up, down) and drives the game core's pause_n, new_game_n, up_key_n and down_key_n inputs.
- Per channel: metastability synchroniser, then counter-based debouncer.
- Derived behaviour: one-cycle new-game strobe, up/down conflict suppression, optional pause toggle latch.
- Runs in the 25 MHz pixel clock domain.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive clk cycles a synchronised input must disagree with its stable state before the stable state flips (10 ms at 25 MHz); legal range ≥2.
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser; legal range ≥2.

Ports:
- clk  input  1  25 MHz pixel clock
- reset  input  1  synchronous, active-high reset
- btn_pause_n  input  1  raw pause button, low = pressed, asynchronous
- btn_new_game_n  input  1  raw new-game button, low = pressed, asynchronous
- btn_up_n  input  1  raw up button, low = pressed, asynchronous
- btn_down_n  input  1  raw down button, low = pressed, asynchronous
- pause_n  output  1  to game core; low = game paused
- new_game_n  output  1  to game core; low for exactly one cycle per debounced new-game press
- up_key_n  output  1  to game core; debounced up level, low = pressed
- down_key_n  output  1  to game core; debounced down level, low = pressed

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high. All state is updated on posedge clk only.
- Reset values:
  - all synchroniser flops 1
  - all stable states 1 (released)
  - all debounce counters 0
  - outputs: pause_n=1, new_game_n=1, up_key_n=1, down_key_n=1
- Reset mid-operation: any counting debounce is aborted, with no partial carry-over.
- Synchroniser: SYNC_STAGES-deep shift register per channel; the last stage is "sync".
- Debouncer, per channel, with counter width $clog2(DEBOUNCE_CYCLES):
  - sync == stable: counter <= 0.
  - sync != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync, counter <= 0.
  - A single cycle of agreement restarts the count, so glitches shorter than DEBOUNCE_CYCLES never propagate.
  - Counter never wraps; saturation is impossible by construction.
- Latency: a raw change held steady flips the stable state on the (SYNC_STAGES + DEBOUNCE_CYCLES)-th rising edge after the first edge that samples the new raw value.
- Press event: registered stable transition 1→0. Release event: 0→1.
- new_game_n:
  - Registered. Goes low the cycle after the new-game press event, for exactly 1 cycle, then returns to 1.
  - Holding the button produces no further strobes; a new strobe requires a debounced release and press.
- up_key_n / down_key_n: registered from the stable states, 1-cycle delay after the stable state flips.
  - Conflict: if both stable states are pressed, both outputs are 1 (no movement).
  - When one button is released, the other output follows its stable state the next cycle.
- pause_n: see Optional Feature.
- A button held through reset release reads as released at first. It registers as a press once the normal latency elapses.
- Channels are fully independent. Simultaneous events on different channels are all honoured in the same cycle.

Optional Feature:
- Macro: PAUSE_TOGGLE_EN.
- Defined:
  - pause_n toggles on each pause press event (registered, 1 cycle after the event). Pause release events are ignored.
  - A new-game press event forces pause_n <= 1 on the same cycle the new_game_n strobe goes low. This overrides a simultaneous pause toggle.
- Undefined:
  - pause_n is the registered pause stable state (held = paused).
  - New game has no effect on pause_n.

Test Plan (DEBOUNCE_CYCLES=8, SYNC_STAGES=2 unless stated):
- Reset: assert reset with all buttons pressed for 5 cycles → all outputs 1 during reset and on the first cycle after release. Then all presses register 10 cycles after release (+1 output register).
- Glitch rejection: pulse btn_up_n low for 7 cycles, high 1 cycle, low 7 cycles → up_key_n stays 1 throughout. Then hold low 8 cycles → up_key_n falls exactly 2+8+1 = 11 cycles after the hold begins.
- New-game strobe: press btn_new_game_n and hold 100 cycles → exactly one cycle of new_game_n=0. Release and press again → exactly one more.
- Up/down conflict: hold up → up_key_n=0. Add down → once down is debounced, both outputs 1. Release up → down_key_n=0 1 cycle after up's stable state flips.
- Pause, PAUSE_TOGGLE_EN defined: two clean press/release cycles → pause_n goes 1→0→1. Pausing then pressing new game → pause_n=1 in the new_game_n strobe cycle.
- Pause, macro undefined: hold pause 20 cycles → pause_n=0 from debounce+1 until 11 cycles after release, then 1.
